// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART sender through a request/idle handshake with a 255-cycle request timeout.
// Define UART_TX_OVERFLOW_FLAG_EN to add the sticky overflow output for dropped writes.
module uart_tx_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [7:0]    TX_DATA,
  output logic          TX_EN,
  input  logic          TX_STATUS,
  // Debug view of the sender FSM: 0 = IDLE, 1 = REQ, 2 = BUSY.
  output logic [1:0]    fsm_state
`ifdef UART_TX_OVERFLOW_FLAG_EN
  ,
  output logic          overflow
`endif
);

  // Handshake: a byte is popped only when the sender reports idle; TX_EN is then
  // raised and held until the sender goes busy (TX_STATUS=0) or the request times
  // out. The next pop waits until the sender reports idle again.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [7:0]  TMO_LAST = 8'd254;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [7:0]    tmo_cnt;
  logic          st_q1;
  logic          st_s;
  logic          wr_acc;
  logic          pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign wr_acc    = wr_en && !full;
  assign pop       = (state == IDLE) && !empty && st_s;
  assign fsm_state = state;

  // TX_STATUS comes from another clock domain; resets to idle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      st_q1 <= 1'b1;
      st_s  <= 1'b1;
    end else begin
      st_q1 <= TX_STATUS;
      st_s  <= st_q1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= IDLE;
      TX_EN   <= 1'b0;
      TX_DATA <= 8'h00;
      tmo_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          TX_EN <= 1'b0;
          if (pop) begin
            TX_DATA <= mem[rd_ptr];
            tmo_cnt <= 8'd0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (!st_s) begin
            TX_EN <= 1'b0;
            state <= BUSY;
          end else if (tmo_cnt == TMO_LAST) begin
            // Sender never acknowledged: the byte is abandoned, not re-queued.
            TX_EN   <= 1'b0;
            tmo_cnt <= 8'd0;
            state   <= IDLE;
          end else begin
            TX_EN   <= 1'b1;
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        BUSY: begin
          TX_EN <= 1'b0;
          if (st_s) begin
            state <= IDLE;
          end
        end
        default: begin
          TX_EN <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_OVERFLOW_FLAG_EN
  always_ff @(posedge sysclk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed scenarios plus a randomized stream checked
// against a byte-queue model with an emulated UART sender.
module tb_uart_tx_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int BAUD  = 4;

  logic          sysclk;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [7:0]    TX_DATA;
  logic          TX_EN;
  logic          TX_STATUS;
  logic [1:0]    fsm_state;
`ifdef UART_TX_OVERFLOW_FLAG_EN
  logic          overflow;
`endif

  logic          st_man;
  logic          st_emu;
  logic          auto_sender;
  logic          prev_en;
  logic [7:0]    obs_q[$];
  logic [7:0]    exp_q[$];
  int            n_cmp;
  int            n_err;

  assign TX_STATUS = auto_sender ? st_emu : st_man;

  uart_tx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .TX_DATA   (TX_DATA),
    .TX_EN     (TX_EN),
    .TX_STATUS (TX_STATUS),
    .fsm_state (fsm_state)
`ifdef UART_TX_OVERFLOW_FLAG_EN
    ,
    .overflow  (overflow)
`endif
  );

  // Clock and reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Sender emulation: on a request, go busy for 10 baud periods.
  initial begin
    st_emu = 1'b1;
    forever begin
      @(negedge sysclk);
      if (auto_sender && TX_EN && st_emu) begin
        st_emu = 1'b0;
        repeat (10 * BAUD) @(negedge sysclk);
        st_emu = 1'b1;
      end
    end
  end

  // Record the byte presented at each rising edge of TX_EN.
  initial begin
    prev_en = 1'b0;
    forever begin
      @(negedge sysclk);
      if (TX_EN && !prev_en) obs_q.push_back(TX_DATA);
      prev_en = TX_EN;
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (obs_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    n_cmp++;
    if (obs_q.size() < n) begin
      n_err++;
      $display("FAIL %s_wait: got %0d bytes, required %0d", tag, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'($urandom);
    tick();
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    n_cmp++; if (TX_EN !== 1'b0)   begin n_err++; $display("FAIL rst_tx_en: got %b required 0", TX_EN); end
    n_cmp++; if (TX_DATA !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h required 00", TX_DATA); end
    n_cmp++; if (count !== '0)     begin n_err++; $display("FAIL rst_count: got %0d required 0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL rst_flags: got empty=%b full=%b required 1 0", empty, full); end
`ifdef UART_TX_OVERFLOW_FLAG_EN
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b required 0", overflow); end
`endif
    tick();
  endtask

  task automatic test_latency();
    int n;
    st_man  = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (count !== 4'd1 || TX_EN !== 1'b0) begin n_err++; $display("FAIL lat_n: got count=%0d tx_en=%b required 1 0", count, TX_EN); end
    tick();
    n_cmp++; if (TX_DATA !== 8'h55 || TX_EN !== 1'b0) begin n_err++; $display("FAIL lat_pop: got data=%h tx_en=%b required 55 0", TX_DATA, TX_EN); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL lat_count: got %0d required 0", count); end
    tick();
    n_cmp++; if (TX_EN !== 1'b1) begin n_err++; $display("FAIL lat_tx_en: got %b required 1", TX_EN); end
    st_man = 1'b0;
    n = 0;
    while (TX_EN === 1'b1 && n < 3) begin
      tick();
      n++;
    end
    n_cmp++; if (TX_EN !== 1'b0) begin n_err++; $display("FAIL lat_drop: got tx_en=%b after %0d cycles required 0", TX_EN, n); end
    st_man = 1'b1;
    repeat (5) tick();
    n_cmp++; if (empty !== 1'b1 || TX_EN !== 1'b0) begin n_err++; $display("FAIL lat_end: got empty=%b tx_en=%b required 1 0", empty, TX_EN); end
  endtask

  task automatic test_fill();
    st_man = 1'b0;
    repeat (3) tick();
    for (int i = 1; i <= 9; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d required 8", count); end
    n_cmp++; if (full !== 1'b1 || empty !== 1'b0) begin n_err++; $display("FAIL fill_flags: got full=%b empty=%b required 1 0", full, empty); end
`ifdef UART_TX_OVERFLOW_FLAG_EN
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow: got %b required 1", overflow); end
`endif
  endtask

  task automatic test_drain();
    obs_q.delete();
    auto_sender = 1'b1;
    wait_obs(8, 3000, "drain");
    repeat (10 * BAUD + 10) tick();
    n_cmp++; if (obs_q.size() != 8) begin n_err++; $display("FAIL drain_size: got %0d required 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      n_cmp++;
      if (obs_q[i] !== 8'(i + 1)) begin n_err++; $display("FAIL drain_byte%0d: got %h required %h", i, obs_q[i], 8'(i + 1)); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b required 1", empty); end
    auto_sender = 1'b0;
    st_man      = 1'b1;
  endtask

  task automatic test_full_pop();
    st_man = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      exp_q.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
    obs_q.delete();
    st_man = 1'b1;
    tick();
    tick();
    // Synchronised idle is seen at the next edge, which pops while still full.
    wr_en   = 1'b1;
    wr_data = 8'($urandom);
    tick();
    wr_en = 1'b0;
    n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL fullpop_count: got %0d required 7", count); end
    auto_sender = 1'b1;
    wait_obs(DEPTH, 3000, "fullpop");
    repeat (10 * BAUD + 10) tick();
    n_cmp++; if (obs_q.size() != DEPTH) begin n_err++; $display("FAIL fullpop_size: got %0d required %0d", obs_q.size(), DEPTH); end
    for (int i = 0; i < obs_q.size() && i < DEPTH; i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fullpop_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    auto_sender = 1'b0;
    st_man      = 1'b1;
  endtask

  task automatic test_timeout();
    logic [7:0] a;
    logic [7:0] b;
    int n;
    a = 8'($urandom);
    b = 8'($urandom);
    st_man  = 1'b1;
    wr_en   = 1'b1;
    wr_data = a;
    tick();
    wr_data = b;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL tmo_simul_count: got %0d required 1", count); end
    n_cmp++; if (TX_DATA !== a) begin n_err++; $display("FAIL tmo_first: got %h required %h", TX_DATA, a); end
    n = 0;
    while (TX_EN !== 1'b1 && n < 5) begin tick(); n++; end
    n = 0;
    while (TX_EN === 1'b1 && n < 400) begin tick(); n++; end
    n_cmp++; if (n < 250 || n > 256) begin n_err++; $display("FAIL tmo_len: got %0d cycles required 250..256", n); end
    n_cmp++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL tmo_idle: got state %0d required 0", fsm_state); end
    tick();
    n_cmp++; if (TX_DATA !== b || count !== 4'd0) begin n_err++; $display("FAIL tmo_next: got data=%h count=%0d required %h 0", TX_DATA, count, b); end
    n = 0;
    while (TX_EN !== 1'b1 && n < 5) begin tick(); n++; end
    n = 0;
    while (TX_EN === 1'b1 && n < 400) begin tick(); n++; end
    repeat (5) tick();
    n_cmp++; if (TX_EN !== 1'b0 || empty !== 1'b1 || TX_DATA !== b) begin n_err++; $display("FAIL tmo_norepush: got tx_en=%b empty=%b data=%h required 0 1 %h", TX_EN, empty, TX_DATA, b); end
  endtask

  task automatic test_reset_mid();
    int n;
    st_man = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    wr_en  = 1'b0;
    st_man = 1'b1;
    n = 0;
    while (TX_EN !== 1'b1 && n < 10) begin tick(); n++; end
    n_cmp++; if (TX_EN !== 1'b1 || count !== 4'd3) begin n_err++; $display("FAIL rmid_setup: got tx_en=%b count=%0d required 1 3", TX_EN, count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (TX_EN !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL rmid: got tx_en=%b count=%0d empty=%b required 0 0 1", TX_EN, count, empty); end
    repeat (5) tick();
    n_cmp++; if (TX_EN !== 1'b0 || TX_DATA !== 8'h00) begin n_err++; $display("FAIL rmid_after: got tx_en=%b data=%h required 0 00", TX_EN, TX_DATA); end
  endtask

  task automatic test_random();
    int pushed;
    int guard;
    obs_q.delete();
    exp_q.delete();
    auto_sender = 1'b1;
    pushed = 0;
    guard  = 0;
    while (pushed < 40 && guard < 20000) begin
      repeat ($urandom_range(0, 3)) tick();
      if (pushed - obs_q.size() < DEPTH) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
        pushed++;
      end
      tick();
      wr_en = 1'b0;
      guard++;
    end
    wait_obs(40, 6000, "rand");
    repeat (10 * BAUD + 10) tick();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_size: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rand_empty: got %b required 1", empty); end
    auto_sender = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    st_man      = 1'b1;
    auto_sender = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_drain();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
